// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared definitions for the UART command parser.
//   - state_t           : parser FSM state encoding
//   - SYNC_BYTE_DEFAULT : default frame start marker
//   - OP_WRITE/OP_READ  : opcodes understood by downstream consumers
//   - frame_csum()      : checksum over the three payload bytes
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

    // Opcodes are decoded by the consumer; the parser passes them through.
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OP   = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_HOLD = 3'd5
    } state_t;

    function automatic logic [7:0] frame_csum(input logic [7:0] op,
                                              input logic [7:0] addr,
                                              input logic [7:0] data);
        return op ^ addr ^ data;
    endfunction

endpackage

// File: rtl/byte_timeout.sv
// byte_timeout: inter-byte watchdog.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   clr    : clears the count (a byte arrived)
//   en     : count while a frame is in progress
//   expire : high in the cycle the count sits at TIMEOUT_CLKS-1, unless a
//            byte arrives in that same cycle (the byte wins)
module byte_timeout #(
    parameter int unsigned TIMEOUT_CLKS = 17360
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned   W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [W-1:0]  LAST = W'(TIMEOUT_CLKS - 1);
    localparam logic [W-1:0]  ONE  = W'(1);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            // Holding at LAST keeps the counter from wrapping before the
            // parser has reacted to the expiry.
            cnt <= cnt + ONE;
        end
    end

    assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames SYNC, op, addr, data, csum bytes from a UART
// receiver into a command handed off with a valid/ready handshake.
//   clk, rst           : system clock, synchronous active-high reset
//   rx_rd, rx_data     : one-cycle strobe with the newly received byte
//   cmd_valid/ready    : command handshake; payload held stable while valid
//   cmd_op/addr/data   : decoded command fields
//   err_cnt            : saturating count of discarded frames/bytes
//   busy               : parser is not idle
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = 17360,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_rd,
    input  logic [7:0] rx_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_op,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic [7:0] err_cnt,
    output logic       busy
);

    state_t state, state_nxt;
    logic   err_inc;
    logic   tmo_en;
    logic   tmo_expire;

    assign tmo_en = (state == ST_OP) || (state == ST_ADDR) ||
                    (state == ST_DATA) || (state == ST_CSUM);

    // Every entry to OP happens on an rx_rd, so clearing on rx_rd covers both
    // the per-byte and the frame-start clear.
    byte_timeout #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (rx_rd),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    // NOTE: defaults first so every path assigns every output of the block;
    // otherwise synthesis infers latches.
    always_comb begin
        state_nxt = state;
        err_inc   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rx_rd && rx_data == SYNC_BYTE) state_nxt = ST_OP;
            end
            ST_OP, ST_ADDR, ST_DATA: begin
                // A SYNC_BYTE value here is payload, not a resync.
                if (rx_rd)           state_nxt = state_t'(state + 3'd1);
                else if (tmo_expire) begin
                    state_nxt = ST_IDLE;
                    err_inc   = 1'b1;
                end
            end
            ST_CSUM: begin
                if (rx_rd) begin
                    if (rx_data == frame_csum(cmd_op, cmd_addr, cmd_data)) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        state_nxt = ST_IDLE;
                        err_inc   = 1'b1;
                    end
                end else if (tmo_expire) begin
                    state_nxt = ST_IDLE;
                    err_inc   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cmd_ready) begin
                    // Handshake completes; a byte arriving now is handled as
                    // if the parser were already idle.
                    state_nxt = (rx_rd && rx_data == SYNC_BYTE) ? ST_OP : ST_IDLE;
                end else if (rx_rd) begin
                    err_inc = 1'b1;      // overrun: byte dropped
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cmd_op   <= '0;
            cmd_addr <= '0;
            cmd_data <= '0;
            err_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (rx_rd) begin
                if (state == ST_OP)   cmd_op   <= rx_data;
                if (state == ST_ADDR) cmd_addr <= rx_data;
                if (state == ST_DATA) cmd_data <= rx_data;
            end
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign cmd_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter TIMEOUT_CLKS, default 17360, inter-byte timeout in clk cycles (4 byte times at 434 clks/bit).
REQ-002 Parameter SYNC_BYTE, default 8'hAA, frame start marker.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx_rd  input  1  one-cycle strobe: rx_data holds a newly received byte.
REQ-006 rx_data  input  8  received byte; sampled only when rx_rd=1.
REQ-007 cmd_valid  output  1  decoded command available.
REQ-008 cmd_ready  input  1  consumer accepts the command.
REQ-009 cmd_op  output  8  command opcode.
REQ-010 cmd_addr  output  8  register address.
REQ-011 cmd_data  output  8  write data or read argument.
REQ-012 err_cnt  output  8  count of discarded frames, saturating.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Frame format: SYNC_BYTE, op, addr, data, csum; csum = op XOR addr XOR data.
REQ-015 States: IDLE, OP, ADDR, DATA, CSUM, HOLD; each state except HOLD advances only on rx_rd.
REQ-016 IDLE: rx_rd with rx_data==SYNC_BYTE -> OP; other bytes are ignored without error.
REQ-017 OP/ADDR/DATA: on rx_rd, latch the byte into the op/addr/data register, then advance OP->ADDR->DATA->CSUM.
REQ-018 CSUM: on rx_rd with a matching checksum -> HOLD; on mismatch -> IDLE and err_cnt+1.
REQ-019 cmd_valid rises on the first cycle after the csum byte's rx_rd cycle (latency 1) and stays high in HOLD.
REQ-020 cmd_op/addr/data stay stable while cmd_valid=1.
REQ-021 HOLD: cmd_valid & cmd_ready -> IDLE, with cmd_valid low on the next cycle.
REQ-022 HOLD: rx_rd without cmd_ready drops the byte and increments err_cnt (overrun).
REQ-023 HOLD: rx_rd and cmd_ready in the same cycle completes the handshake; the byte is then processed as in IDLE (SYNC_BYTE -> OP), with no error.
REQ-024 Timeout: a counter clears on every rx_rd and on entry to OP.
REQ-025 Timeout: the counter increments in OP/ADDR/DATA/CSUM only.
REQ-026 Timeout: when the counter reaches TIMEOUT_CLKS-1, the block goes to IDLE and increments err_cnt.
REQ-027 Timeout: no timeout applies in IDLE or HOLD.
REQ-028 Timeout: if rx_rd and timeout expiry occur in the same cycle, the byte wins and the counter clears.
REQ-029 err_cnt saturates at 8'hFF; coincident error sources in one cycle add 1, not 2.
REQ-030 A SYNC_BYTE value inside a frame is treated as data; no mid-frame resync except by timeout.
REQ-031 Timeout counter width = $clog2(TIMEOUT_CLKS); no wrap before expiry.

Reset
REQ-032 rst has priority over all other inputs and takes effect on the next clock edge.
REQ-033 On reset: state=IDLE; cmd_valid=0; cmd_op/addr/data=0; err_cnt=0; busy=0; timeout counter=0.
REQ-034 Reset mid-frame or in HOLD discards the partial or pending command without counting an error.

Structure
REQ-035 Package uart_cmd_pkg holds the state enum, the SYNC_BYTE default, and opcodes OP_WRITE=8'h01 and OP_READ=8'h02.
REQ-036 The parser does not check opcodes; opcode checking belongs to the consumer.
REQ-037 One sub-module, byte_timeout (parameterised clear/enable/expire counter), implements REQ-024 to REQ-028.

Verification
REQ-038 Frame AA 01 10 5C 4D with cmd_ready=1 -> cmd_valid pulses 1 cycle after the 4D strobe, op=01, addr=10, data=5C; err_cnt=0.
REQ-039 Frame AA 01 10 5C 00 (bad csum) -> no cmd_valid; err_cnt=1; state=IDLE.
REQ-040 Bytes 55 AA 02 20, then no strobes for TIMEOUT_CLKS cycles -> err_cnt=1 and busy=0 at expiry; a following valid frame decodes correctly.
REQ-041 Valid frame with cmd_ready=0, extra byte 33 arrives -> err_cnt=1, outputs unchanged; then cmd_ready=1 together with rx_rd of AA -> handshake completes and state=OP.
REQ-042 Apply rst after AA 01 10 -> all outputs zero next cycle; err_cnt=0.
REQ-043 Send 300 bad-checksum frames -> err_cnt holds at FF.
